// File: rtl/bus_controller_if.sv
// Instruction-fetch handshake between the bus controller (master) and instruction memory (slave).
interface bus_controller_if #(
  parameter int PC_W = 8
);
  logic            imem_req;
  logic [PC_W-1:0] imem_addr;
  logic            imem_ack;
  logic [15:0]     imem_data;

  modport master (output imem_req, output imem_addr, input imem_ack, input imem_data);
  modport slave  (input imem_req, input imem_addr, output imem_ack, output imem_data);
endinterface

// File: rtl/bus_controller.sv
// FETCH/DECODE/EXEC sequencer that writes back into the t0..t3 register file over BUS/LD.
// Optional carry flag, ADC and JC are enabled with `define BUS_CONTROLLER_CARRY_EN.
module bus_controller #(
  parameter int              PC_W     = 8,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst,
  bus_controller_if.master   imem,
  input  logic [15:0]        t0,
  input  logic [15:0]        t1,
  input  logic [15:0]        t2,
  input  logic [15:0]        t3,
  input  logic [15:0]        i0,
  input  logic [15:0]        i1,
  input  logic [15:0]        const_i,
  output logic [15:0]        BUS,
  output logic [3:0]         LD,
  output logic               zflag,
  output logic               halted
`ifdef BUS_CONTROLLER_CARRY_EN
  ,
  output logic               cflag
`endif
);

  typedef enum logic [1:0] {
    FETCH  = 2'd0,
    DECODE = 2'd1,
    EXEC   = 2'd2,
    HALT   = 2'd3
  } state_e;

  state_e          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [15:0]     ir_q, ir_d;
  logic            req_q, req_d;
  logic [15:0]     res_q, res_d;
  logic            wr_q, wr_d;
  logic            br_q, br_d;
  logic [15:0]     bus_q, bus_d;
  logic [3:0]      ld_q, ld_d;
  logic            z_q, z_d;
`ifdef BUS_CONTROLLER_CARRY_EN
  logic            c_q, c_d;
  logic            rc_q, rc_d;
  logic            cw_q, cw_d;
`endif

  logic [3:0]      op;
  logic [15:0]     op_a, op_b;
  logic [15:0]     alu_res;
  logic            alu_wr;
  logic            br_take;
`ifdef BUS_CONTROLLER_CARRY_EN
  logic            alu_c;
  logic            alu_cw;
  logic [16:0]     wide;
`endif

  function automatic logic [15:0] pick_src(input logic [2:0] s,
                                           input logic [15:0] r0, input logic [15:0] r1,
                                           input logic [15:0] r2, input logic [15:0] r3,
                                           input logic [15:0] k0, input logic [15:0] k1,
                                           input logic [15:0] k2);
    case (s)
      3'd0:    pick_src = r0;
      3'd1:    pick_src = r1;
      3'd2:    pick_src = r2;
      3'd3:    pick_src = r3;
      3'd4:    pick_src = k0;
      3'd5:    pick_src = k1;
      3'd6:    pick_src = k2;
      default: pick_src = 16'h0000;
    endcase
  endfunction

  assign op   = ir_q[15:12];
  assign op_a = pick_src(ir_q[9:7], t0, t1, t2, t3, i0, i1, const_i);
  assign op_b = pick_src(ir_q[6:4], t0, t1, t2, t3, i0, i1, const_i);

  always_comb begin
    alu_res = 16'h0000;
    alu_wr  = 1'b0;
    br_take = 1'b0;
`ifdef BUS_CONTROLLER_CARRY_EN
    alu_c   = c_q;
    alu_cw  = 1'b0;
    wide    = 17'h0;
`endif
    case (op)
      4'h1: begin alu_res = op_a;                  alu_wr = 1'b1; end
`ifdef BUS_CONTROLLER_CARRY_EN
      4'h2: begin
        wide    = {1'b0, op_a} + {1'b0, op_b};
        alu_res = wide[15:0];
        alu_c   = wide[16];
        alu_cw  = 1'b1;
        alu_wr  = 1'b1;
      end
      // Borrow shows up as bit 16 of the zero-extended difference.
      4'h3: begin
        wide    = {1'b0, op_a} - {1'b0, op_b};
        alu_res = wide[15:0];
        alu_c   = wide[16];
        alu_cw  = 1'b1;
        alu_wr  = 1'b1;
      end
      4'h9: begin
        wide    = {1'b0, op_a} + {1'b0, op_b} + {16'h0000, c_q};
        alu_res = wide[15:0];
        alu_c   = wide[16];
        alu_cw  = 1'b1;
        alu_wr  = 1'b1;
      end
      4'hA: br_take = c_q;
`else
      4'h2: begin alu_res = op_a + op_b;           alu_wr = 1'b1; end
      4'h3: begin alu_res = op_a - op_b;           alu_wr = 1'b1; end
`endif
      4'h4: begin alu_res = op_a & op_b;           alu_wr = 1'b1; end
      4'h5: begin alu_res = op_a | op_b;           alu_wr = 1'b1; end
      4'h6: begin alu_res = {8'h00, ir_q[7:0]};    alu_wr = 1'b1; end
      4'h7: br_take = 1'b1;
      4'h8: br_take = z_q;
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    req_d   = req_q;
    res_d   = res_q;
    wr_d    = wr_q;
    br_d    = br_q;
    bus_d   = bus_q;
    ld_d    = 4'b0000;
    z_d     = z_q;
`ifdef BUS_CONTROLLER_CARRY_EN
    c_d     = c_q;
    rc_d    = rc_q;
    cw_d    = cw_q;
`endif
    case (state_q)
      // req_q is low for the first FETCH cycle after reset, so a stale ack is never taken.
      FETCH: begin
        req_d = 1'b1;
        if (req_q && imem.imem_ack) begin
          ir_d    = imem.imem_data;
          req_d   = 1'b0;
          state_d = DECODE;
        end
      end
      DECODE: begin
        res_d = alu_res;
        wr_d  = alu_wr;
        br_d  = br_take;
`ifdef BUS_CONTROLLER_CARRY_EN
        rc_d  = alu_c;
        cw_d  = alu_cw;
`endif
        if (alu_wr) begin
          bus_d = alu_res;
          ld_d  = 4'b1000 >> ir_q[11:10];
        end
        state_d = EXEC;
      end
      EXEC: begin
        if (wr_q) z_d = (res_q == 16'h0000);
`ifdef BUS_CONTROLLER_CARRY_EN
        if (cw_q) c_d = rc_q;
`endif
        pc_d = br_q ? PC_W'(ir_q[7:0]) : pc_q + PC_W'(1);
        if (op == 4'hF) begin
          state_d = HALT;
        end else begin
          state_d = FETCH;
          req_d   = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= FETCH;
      pc_q    <= RESET_PC;
      ir_q    <= 16'h0000;
      req_q   <= 1'b0;
      res_q   <= 16'h0000;
      wr_q    <= 1'b0;
      br_q    <= 1'b0;
      bus_q   <= 16'h0000;
      ld_q    <= 4'b0000;
      z_q     <= 1'b0;
`ifdef BUS_CONTROLLER_CARRY_EN
      c_q     <= 1'b0;
      rc_q    <= 1'b0;
      cw_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      req_q   <= req_d;
      res_q   <= res_d;
      wr_q    <= wr_d;
      br_q    <= br_d;
      bus_q   <= bus_d;
      ld_q    <= ld_d;
      z_q     <= z_d;
`ifdef BUS_CONTROLLER_CARRY_EN
      c_q     <= c_d;
      rc_q    <= rc_d;
      cw_q    <= cw_d;
`endif
    end
  end

  assign imem.imem_req  = req_q;
  assign imem.imem_addr = pc_q;
  assign BUS            = bus_q;
  assign LD             = ld_q;
  assign zflag          = z_q;
  assign halted         = (state_q == HALT);
`ifdef BUS_CONTROLLER_CARRY_EN
  assign cflag          = c_q;
`endif

endmodule
